// File: rtl/rx_pkg.sv
// Shared definitions for the receive byte packer: FSM state encoding,
// Gen2 CRC-16 constants and the partial-byte padding helper.
package rx_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      COLLECT = 3'd1,
      PUSH    = 3'd2,
      DROP    = 3'd3,
      DONE    = 3'd4
   } rx_state_e;

   localparam logic [15:0] CRC16_POLY    = 16'h1021;
   localparam logic [15:0] CRC16_PRESET  = 16'hFFFF;
   localparam logic [15:0] CRC16_RESIDUE = 16'h1D0F;

   // Move the n received bits of a partial byte into their final positions
   // and zero-fill the slots that were never received.
   function automatic logic [7:0] pad_partial(input logic [7:0] sh,
                                              input logic [2:0] n,
                                              input logic       msb_first);
      logic [3:0] gap;
      gap = 4'd8 - {1'b0, n};
      if (msb_first)
         return sh << gap;
      else
         return sh >> gap;
   endfunction

endpackage

// File: rtl/rx_crc16.sv
// Serial bit-wise Gen2 CRC-16 (x^16 + x^12 + x^5 + 1), MSB-first feedback.
// init presets the register; enable folds bit_in into it.
module rx_crc16
   import rx_pkg::*;
(
   input  logic        w_clk,
   input  logic        reset_n,
   input  logic        init,
   input  logic        enable,
   input  logic        bit_in,
   output logic [15:0] crc
);

   logic fb;

   assign fb = crc[15] ^ bit_in;

   // Shift one bit per enabled cycle; preset has priority over a data bit.
   always_ff @(posedge w_clk or negedge reset_n) begin
      if (!reset_n)
         crc <= CRC16_PRESET;
      else if (init)
         crc <= CRC16_PRESET;
      else if (enable)
         crc <= {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
   end

endmodule

// File: rtl/rx_byte_packer.sv
// Packs decoded serial bits into bytes and pushes them into the receive FIFO,
// tracking per-frame byte count, overflow and trailing partial bits.
// Optional build macro RX_CRC16_CHECK_EN adds a Gen2 CRC-16 check and the
// crc_ok status output.
module rx_byte_packer
   import rx_pkg::*;
#(
   parameter int MAX_BYTES = 64,
   parameter int CNT_W     = 7,
   parameter bit MSB_FIRST = 1'b1
)(
   input  logic             w_clk,
   input  logic             reset_n,
   input  logic             en,
   input  logic             frame_start,
   input  logic             frame_end,
   input  logic             bit_valid,
   input  logic             bit_in,
   input  logic             fifo_full,
   output logic             fifo_write,
   output logic [7:0]       fifo_data,
   output logic             frame_done,
   output logic [CNT_W-1:0] byte_count,
   output logic [2:0]       trailing_bits,
   output logic             overflow,
   output logic             busy
`ifdef RX_CRC16_CHECK_EN
   ,
   output logic             crc_ok
`endif
);

   rx_state_e  state;
   logic [7:0] shift_q;
   logic [2:0] bit_cnt;
   logic       end_pending;

   logic [7:0] sh_nxt;
   logic [2:0] cnt_nxt;
   logic [7:0] cur_sh;
   logic [2:0] cur_cnt;
   logic       byte_done;
   logic       push_accept;

   // Next shift-register value and bit count assuming bit_in is taken now;
   // cur_* reflect the register after this cycle's bit (if any) for end handling.
   always_comb begin
      sh_nxt      = MSB_FIRST ? {shift_q[6:0], bit_in} : {bit_in, shift_q[7:1]};
      cnt_nxt     = bit_cnt + 3'd1;
      cur_sh      = bit_valid ? sh_nxt  : shift_q;
      cur_cnt     = bit_valid ? cnt_nxt : bit_cnt;
      byte_done   = bit_valid && (bit_cnt == 3'd7);
      push_accept = bit_valid && !end_pending;
   end

   assign fifo_write = (state == PUSH) && !fifo_full && en;
   assign busy       = (state != IDLE);

   // Frame FSM with registered status outputs and the byte hold register.
   always_ff @(posedge w_clk or negedge reset_n) begin
      if (!reset_n) begin
         state         <= IDLE;
         shift_q       <= 8'h00;
         bit_cnt       <= 3'd0;
         end_pending   <= 1'b0;
         fifo_data     <= 8'h00;
         frame_done    <= 1'b0;
         byte_count    <= '0;
         trailing_bits <= 3'd0;
         overflow      <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (!en) begin
            state       <= IDLE;
            end_pending <= 1'b0;
         end else if (frame_start) begin
            // Start (or restart) a frame; a concurrent bit is discarded.
            state         <= COLLECT;
            bit_cnt       <= 3'd0;
            end_pending   <= 1'b0;
            byte_count    <= '0;
            trailing_bits <= 3'd0;
            overflow      <= 1'b0;
         end else begin
            case (state)
               IDLE: ;
               COLLECT: begin
                  if (bit_valid) begin
                     shift_q <= sh_nxt;
                     bit_cnt <= cnt_nxt;
                  end
                  if (byte_done) begin
                     fifo_data   <= sh_nxt;
                     end_pending <= frame_end;
                     state       <= PUSH;
                  end else if (frame_end) begin
                     if (cur_cnt == 3'd0) begin
                        state      <= DONE;
                        frame_done <= 1'b1;
                     end else begin
                        fifo_data     <= pad_partial(cur_sh, cur_cnt, MSB_FIRST);
                        trailing_bits <= cur_cnt;
                        bit_cnt       <= 3'd0;
                        end_pending   <= 1'b1;
                        state         <= PUSH;
                     end
                  end
               end
               PUSH: begin
                  if (frame_end)
                     end_pending <= 1'b1;
                  if (push_accept) begin
                     shift_q <= sh_nxt;
                     bit_cnt <= cnt_nxt;
                  end
                  if (fifo_write) begin
                     if (byte_count < CNT_W'(MAX_BYTES))
                        byte_count <= byte_count + 1'b1;
                     if (push_accept && byte_done) begin
                        // Held byte leaves on this edge, so the new one takes its place.
                        fifo_data <= sh_nxt;
                        state     <= PUSH;
                     end else if (end_pending || frame_end) begin
                        state      <= DONE;
                        frame_done <= 1'b1;
                     end else begin
                        state <= COLLECT;
                     end
                  end else if (push_accept && byte_done) begin
                     // Second byte completed with the first still stuck: frame is lost.
                     overflow <= 1'b1;
                     if (frame_end) begin
                        state      <= DONE;
                        frame_done <= 1'b1;
                     end else begin
                        state <= DROP;
                     end
                  end
               end
               DROP: begin
                  if (frame_end) begin
                     state      <= DONE;
                     frame_done <= 1'b1;
                  end
               end
               DONE: state <= IDLE;
               default: state <= IDLE;
            endcase
         end
      end
   end

`ifdef RX_CRC16_CHECK_EN
   logic        crc_init;
   logic        crc_en;
   logic [15:0] crc_val;

   assign crc_init = en && frame_start;
   assign crc_en   = en && !frame_start && bit_valid &&
                     ((state == COLLECT) || ((state == PUSH) && !end_pending));

   rx_crc16 u_crc (
      .w_clk   (w_clk),
      .reset_n (reset_n),
      .init    (crc_init),
      .enable  (crc_en),
      .bit_in  (bit_in),
      .crc     (crc_val)
   );

   // Latch the frame's CRC verdict while the FSM sits in DONE.
   always_ff @(posedge w_clk or negedge reset_n) begin
      if (!reset_n)
         crc_ok <= 1'b0;
      else if (en && (state == DONE))
         crc_ok <= (crc_val == CRC16_RESIDUE) && (trailing_bits == 3'd0);
   end
`endif

endmodule

// File: tb/tb_rx_byte_packer.sv
// Directed testbench for rx_byte_packer (default parameters, MSB first).
// Under RX_CRC16_CHECK_EN it also exercises crc_ok.
module tb_rx_byte_packer;

   logic       w_clk;
   logic       reset_n;
   logic       en;
   logic       frame_start;
   logic       frame_end;
   logic       bit_valid;
   logic       bit_in;
   logic       fifo_full;
   logic       fifo_write;
   logic [7:0] fifo_data;
   logic       frame_done;
   logic [6:0] byte_count;
   logic [2:0] trailing_bits;
   logic       overflow;
   logic       busy;
`ifdef RX_CRC16_CHECK_EN
   logic       crc_ok;
`endif

   int         n_tests = 0;
   int         n_fail  = 0;
   int         done_cnt = 0;
   logic [7:0] wr_q[$];

   rx_byte_packer dut (
      .w_clk         (w_clk),
      .reset_n       (reset_n),
      .en            (en),
      .frame_start   (frame_start),
      .frame_end     (frame_end),
      .bit_valid     (bit_valid),
      .bit_in        (bit_in),
      .fifo_full     (fifo_full),
      .fifo_write    (fifo_write),
      .fifo_data     (fifo_data),
      .frame_done    (frame_done),
      .byte_count    (byte_count),
      .trailing_bits (trailing_bits),
      .overflow      (overflow),
      .busy          (busy)
`ifdef RX_CRC16_CHECK_EN
      ,
      .crc_ok        (crc_ok)
`endif
   );

   initial w_clk = 1'b0;
   always #5 w_clk = ~w_clk;

   // Record every FIFO write and frame_done pulse, sampled mid-cycle.
   always @(negedge w_clk) begin
      if (fifo_write)
         wr_q.push_back(fifo_data);
      if (frame_done)
         done_cnt++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge w_clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      bit_valid = 1'b1;
      bit_in    = b;
      tick();
      bit_valid = 1'b0;
      bit_in    = 1'b0;
      tick();
   endtask

   task automatic send_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--)
         send_bit(b[i]);
   endtask

   task automatic pulse_start();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      tick();
   endtask

   task automatic end_frame(input string tag);
      int  base;
      bit  seen;
      base = done_cnt;
      seen = 1'b0;
      frame_end = 1'b1;
      tick();
      frame_end = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (done_cnt != base) begin
            seen = 1'b1;
            break;
         end
         tick();
      end
      check({tag, "_frame_done"}, 32'(seen), 32'd1);
   endtask

   function automatic logic [31:0] wr_at(input int i);
      if (wr_q.size() > i)
         return 32'(wr_q[i]);
      return 32'hDEAD;
   endfunction

`ifdef RX_CRC16_CHECK_EN
   function automatic logic [15:0] ref_crc(input logic [7:0] d);
      logic [15:0] c;
      logic        fb;
      c = 16'hFFFF;
      for (int i = 7; i >= 0; i--) begin
         fb = c[15] ^ d[i];
         c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
      end
      return ~c;
   endfunction
`endif

   initial begin
      int base;
      reset_n     = 1'b0;
      en          = 1'b1;
      frame_start = 1'b0;
      frame_end   = 1'b0;
      bit_valid   = 1'b0;
      bit_in      = 1'b0;
      fifo_full   = 1'b0;
      repeat (3) tick();

      // Reset state
      check("rst_fifo_write", 32'(fifo_write), 32'd0);
      check("rst_fifo_data", 32'(fifo_data), 32'h00);
      check("rst_frame_done", 32'(frame_done), 32'd0);
      check("rst_byte_count", 32'(byte_count), 32'd0);
      check("rst_trailing", 32'(trailing_bits), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      reset_n = 1'b1;
      tick();

      // T1: two full bytes
      wr_q.delete();
      pulse_start();
      check("t1_busy", 32'(busy), 32'd1);
      send_byte(8'hA5);
      send_byte(8'h3C);
      end_frame("t1");
      check("t1_nwr", 32'(wr_q.size()), 32'd2);
      check("t1_wr0", wr_at(0), 32'hA5);
      check("t1_wr1", wr_at(1), 32'h3C);
      check("t1_count", 32'(byte_count), 32'd2);
      check("t1_trail", 32'(trailing_bits), 32'd0);
      check("t1_ovf", 32'(overflow), 32'd0);
      tick();
      check("t1_idle", 32'(busy), 32'd0);

      // T2: 11 bits -> 0xB2 then padded 0xE0
      wr_q.delete();
      pulse_start();
      send_byte(8'hB2);
      send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
      end_frame("t2");
      check("t2_nwr", 32'(wr_q.size()), 32'd2);
      check("t2_wr0", wr_at(0), 32'hB2);
      check("t2_wr1", wr_at(1), 32'hE0);
      check("t2_trail", 32'(trailing_bits), 32'd3);
      check("t2_count", 32'(byte_count), 32'd2);

      // T3: FIFO full for the whole frame -> overflow, nothing written
      wr_q.delete();
      fifo_full = 1'b1;
      pulse_start();
      check("t3_trail_cleared", 32'(trailing_bits), 32'd0);
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
      end_frame("t3");
      check("t3_nwr", 32'(wr_q.size()), 32'd0);
      check("t3_ovf", 32'(overflow), 32'd1);
      check("t3_count", 32'(byte_count), 32'd0);
      fifo_full = 1'b0;
      tick();

      // T4: FIFO full briefly after the first byte; bits keep flowing
      wr_q.delete();
      pulse_start();
      check("t4_ovf_cleared", 32'(overflow), 32'd0);
      send_bit(0); send_bit(1); send_bit(0); send_bit(1);
      send_bit(1); send_bit(0); send_bit(1);
      fifo_full = 1'b1;
      send_bit(0);
      send_bit(1); send_bit(1);
      check("t4_no_wr_while_full", 32'(wr_q.size()), 32'd0);
      fifo_full = 1'b0;
      send_bit(0); send_bit(0); send_bit(0); send_bit(0); send_bit(1); send_bit(1);
      end_frame("t4");
      check("t4_nwr", 32'(wr_q.size()), 32'd2);
      check("t4_wr0", wr_at(0), 32'h5A);
      check("t4_wr1", wr_at(1), 32'hC3);
      check("t4_ovf", 32'(overflow), 32'd0);
      check("t4_count", 32'(byte_count), 32'd2);

      // T5: restart mid-frame after 12 bits
      wr_q.delete();
      base = done_cnt;
      pulse_start();
      send_byte(8'h81);
      send_bit(1); send_bit(0); send_bit(1); send_bit(0);
      pulse_start();
      send_byte(8'hFF);
      end_frame("t5");
      check("t5_nwr", 32'(wr_q.size()), 32'd2);
      check("t5_wr0", wr_at(0), 32'h81);
      check("t5_wr1", wr_at(1), 32'hFF);
      check("t5_count", 32'(byte_count), 32'd1);
      check("t5_trail", 32'(trailing_bits), 32'd0);
      check("t5_one_done", 32'(done_cnt - base), 32'd1);

      // T6: en low mid-frame -> idle, status held, no write
      wr_q.delete();
      pulse_start();
      send_byte(8'hAA);
      send_bit(1); send_bit(1);
      en = 1'b0;
      tick();
      check("t6_busy", 32'(busy), 32'd0);
      check("t6_count_held", 32'(byte_count), 32'd1);
      check("t6_fifo_write", 32'(fifo_write), 32'd0);
      check("t6_nwr", 32'(wr_q.size()), 32'd1);
      en = 1'b1;
      tick();

      // T7: async reset while a push is pending
      fifo_full = 1'b1;
      pulse_start();
      send_byte(8'h77);
      check("t7_held", 32'(fifo_data), 32'h77);
      fifo_full = 1'b0;
      #1;
      check("t7_write_up", 32'(fifo_write), 32'd1);
      reset_n = 1'b0;
      #1;
      check("t7_write_drop", 32'(fifo_write), 32'd0);
      check("t7_busy", 32'(busy), 32'd0);
      check("t7_data", 32'(fifo_data), 32'h00);
      tick();
      reset_n = 1'b1;
      tick();

`ifdef RX_CRC16_CHECK_EN
      // T8: payload 0x00 with its correct CRC, then with a flipped bit
      begin
         logic [15:0] c;
         c = ref_crc(8'h00);
         pulse_start();
         send_byte(8'h00);
         send_byte(c[15:8]);
         send_byte(c[7:0]);
         end_frame("t8a");
         tick();
         check("t8_crc_ok", 32'(crc_ok), 32'd1);
         pulse_start();
         send_byte(8'h01);
         send_byte(c[15:8]);
         send_byte(c[7:0]);
         end_frame("t8b");
         tick();
         check("t8_crc_bad", 32'(crc_ok), 32'd0);
      end
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
